// File: rtl/count_responder.sv
// Counting responder: latches a per-request limit, counts one per clock, and
// signals terminal count with a combinational exit and a registered done pulse.
module count_responder #(
    parameter int unsigned CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req,
    input  logic [CW-1:0] len,
    input  logic          abort,
    output logic          ack,
    output logic          busy,
    output logic [CW-1:0] count,
    output logic          exit,
    output logic          done,
    output logic          ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_d;
    logic [CW-1:0] lim_q;
    logic [CW-1:0] lim_d;
    logic [CW-1:0] pend_len;
    logic [CW-1:0] pend_len_d;
    logic [CW-1:0] count_d;
    logic          pend;
    logic          pend_d;
    logic          ack_d;
    logic          ovf_d;
    logic          queue_req;

    assign exit = (state == RUN) && !abort && (count >= lim_q);

    always_comb begin
        state_d    = state;
        lim_d      = lim_q;
        pend_d     = pend;
        pend_len_d = pend_len;
        ack_d      = 1'b0;
        ovf_d      = 1'b0;
        queue_req  = 1'b0;

        case (state)
            IDLE: begin
                if (req) begin
                    state_d = RUN;
                    lim_d   = len;
                    ack_d   = 1'b1;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    pend_d  = 1'b0;
                end else begin
                    if (count >= lim_q) begin
                        state_d = DONE;
                    end
                    queue_req = req;
                end
            end
            DONE: begin
                if (pend) begin
                    state_d   = RUN;
                    lim_d     = pend_len;
                    pend_d    = 1'b0;
                    queue_req = req;
                end else if (req) begin
                    state_d = RUN;
                    lim_d   = len;
                    ack_d   = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Slot availability is judged after consumption, so a request landing on
        // the cycle the pending entry is launched refills the slot instead of dropping.
        if (queue_req) begin
            if (!pend_d) begin
                pend_d     = 1'b1;
                pend_len_d = len;
                ack_d      = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end

        if ((state == RUN) && (state_d != IDLE)) begin
            count_d = count + 1'b1;
        end else begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            lim_q    <= '0;
            pend     <= 1'b0;
            pend_len <= '0;
            count    <= '0;
            ack      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            state    <= state_d;
            lim_q    <= lim_d;
            pend     <= pend_d;
            pend_len <= pend_len_d;
            count    <= count_d;
            ack      <= ack_d;
            busy     <= (state_d == RUN) || (state_d == DONE);
            done     <= (state_d == DONE);
            ovf      <= ovf_d;
        end
    end

endmodule
